// File: rtl/sys_clk_ctrl.sv
// sys_clk_ctrl: CPU tick generator with free-run, halt and single-step modes plus a debug channel selector.
// Ports:
//    clk            system clock, rising-edge active
//    SYS_reset      asynchronous active-high reset
//    SYS_mode       0 = free-run, 1 = single-step
//    SYS_halt       halt request level, overrides SYS_mode
//    SYS_step       step request level, rising edge used in single-step
//    SYS_output_sel channel shown on SYS_leds
//    SYS_ch_data    packed channels, channel k at [k*DW +: DW]
//    CPU_tick       one-cycle processor advance enable
//    CLK_led        toggles on every tick
//    SYS_leds       registered selected channel (zero when out of range)
//    SYS_state      00 RUN, 01 HALT, 10 STEP
//    tick_count     wrapping count of ticks issued
module sys_clk_ctrl #(
   parameter int unsigned DIVISOR = 4,
   parameter int unsigned NCH = 8,
   parameter int unsigned DW = 8,
   localparam int unsigned SEL_W = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             SYS_reset,
   input  logic             SYS_mode,
   input  logic             SYS_halt,
   input  logic             SYS_step,
   input  logic [SEL_W-1:0] SYS_output_sel,
   input  logic [NCH*DW-1:0] SYS_ch_data,
   output logic             CPU_tick,
   output logic             CLK_led,
   output logic [DW-1:0]    SYS_leds,
   output logic [1:0]       SYS_state,
   output logic [15:0]      tick_count
);
   localparam int unsigned CW = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
   typedef enum logic [1:0] {RUN = 2'b00, HALT = 2'b01, STEP = 2'b10} state_e;
   state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic step_q, step_edge;
   logic tick_q, tick_d, led_q;
   logic [DW-1:0] leds_q, leds_d;
   logic [15:0] count_q;
   logic [DW-1:0] ch [2**SEL_W];
   // Pad the channel table to a power of two so unused selects read zero.
   for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ch
      if (k < NCH) begin : g_on
         assign ch[k] = SYS_ch_data[k*DW +: DW];
      end else begin : g_off
         assign ch[k] = '0;
      end
   end
   // The tick is decided against the next state, so a halt or mode change in the
   // deciding cycle suppresses it, and counting restarts from 0 on RUN entry.
   always_comb begin
      state_d = SYS_halt ? HALT : SYS_mode ? STEP : RUN;
      step_edge = SYS_step & ~step_q;
      cnt_d = (state_d != RUN || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      tick_d = (state_d == RUN) ? (cnt_q == LAST) : (state_q == STEP && state_d == STEP && step_edge);
      leds_d = ch[SYS_output_sel];
   end
   always_ff @(posedge clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         state_q <= RUN;
         cnt_q <= '0;
         step_q <= 1'b0;
         tick_q <= 1'b0;
         led_q <= 1'b0;
         leds_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         step_q <= SYS_step;
         tick_q <= tick_d;
         led_q <= led_q ^ tick_d;
         leds_q <= leds_d;
         count_q <= count_q + {15'd0, tick_d};
      end
   end
   assign CPU_tick = tick_q;
   assign CLK_led = led_q;
   assign SYS_leds = leds_q;
   assign SYS_state = state_q;
   assign tick_count = count_q;
endmodule
